// File: rtl/apb_uart_master.sv
// Single-transfer APB3/APB4 initiator: valid/ready command in, valid/ready response out.
// Optional ACCESS wait-state abort is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_uart_master #(
  parameter logic [31:0] BASE_ADDR = 32'hC300_0000,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic        pclk,
  input  logic        prst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_offset,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_strb,
  input  logic [2:0]  cmd_prot,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  output logic [2:0]  pprot,
  input  logic        pready,
  input  logic [31:0] prdata,
  input  logic        pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state;

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("apb_uart_master: TIMEOUT out of range 2..65535");
  end

  assign cmd_ready = (state == IDLE) && !prst;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

  logic [15:0] wait_cnt;
  logic        timeout_hit;

  // Abort on the edge where this wait cycle would make the count reach the limit.
  assign timeout_hit = (wait_cnt + 16'd1) == TO_LIMIT;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge pclk) begin
    if (prst) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= 32'h0;
      pwdata    <= 32'h0;
      pstrb     <= 4'h0;
      pprot     <= 3'h0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      rsp_timeout <= 1'b0;
      wait_cnt    <= 16'h0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state   <= SETUP;
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= cmd_write;
            paddr   <= BASE_ADDR + cmd_offset;
            pwdata  <= cmd_wdata;
            // Reads must present all-zero strobes on APB4.
            pstrb   <= cmd_write ? cmd_strb : 4'h0;
            pprot   <= cmd_prot;
          end
        end

        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
          wait_cnt <= 16'h0;
`endif
        end

        ACCESS: begin
          if (pready) begin
            state     <= RESP;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= pwrite ? 32'h0 : prdata;
            rsp_err   <= pslverr;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_timeout <= 1'b0;
          end else if (timeout_hit) begin
            state       <= RESP;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= 32'h0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
`endif
          end
        end

        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
